// File: rtl/karatsuba_seq_ctrl.sv
// Sequencer for a 2-way Karatsuba carry-less (GF(2)) multiplier: one bit-serial shift/XOR
// engine computes P0, P2 and P1 in turn, then they are recombined into the 2N-bit product.
module karatsuba_seq_ctrl #(
    parameter int N = 521
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] c,
    output logic           busy,
    output logic [1:0]     phase
);
    localparam int L    = N / 2;
    localparam int H    = N - L;
    localparam int AW   = 2 * H - 1;
    localparam int CW   = 2 * N;
    localparam int CNTW = $clog2(H);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(H - 1);
    localparam logic [1:0] PH_P0   = 2'd0;
    localparam logic [1:0] PH_P2   = 2'd1;
    localparam logic [1:0] PH_P1   = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_COMB = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [N-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic [1:0]      ph_r;
    logic [CNTW-1:0] cnt_r;
    logic [AW-1:0]   acc_r;
    logic [AW-1:0]   p0_r;
    logic [AW-1:0]   p1_r;
    logic [AW-1:0]   p2_r;

    logic [H-1:0]    mcand_s;
    logic [H-1:0]    mplier_s;
    logic [AW-1:0]   term_s;
    logic [AW-1:0]   acc_nx_s;
    logic [AW-1:0]   mid_s;
    logic [CW-1:0]   c_nx_s;

    // Half-size operand selection for the current product; low halves are zero-extended to H bits
    always_comb begin
        mcand_s  = '0;
        mplier_s = '0;
        case (ph_r)
            PH_P0: begin
                mcand_s  = H'(a_r[L-1:0]);
                mplier_s = H'(b_r[L-1:0]);
            end
            PH_P2: begin
                mcand_s  = a_r[N-1:L];
                mplier_s = b_r[N-1:L];
            end
            PH_P1: begin
                mcand_s  = a_r[N-1:L] ^ H'(a_r[L-1:0]);
                mplier_s = b_r[N-1:L] ^ H'(b_r[L-1:0]);
            end
            default: begin
                mcand_s  = '0;
                mplier_s = '0;
            end
        endcase
    end

    // One shift-and-XOR step, plus the Karatsuba recombination (pure XOR, no carries)
    always_comb begin
        term_s = '0;
        if (mplier_s[cnt_r]) begin
            term_s = AW'(mcand_s) << cnt_r;
        end else begin
            term_s = '0;
        end
        acc_nx_s = acc_r ^ term_s;
        mid_s    = p1_r ^ p0_r ^ p2_r;
        c_nx_s   = (CW'(p2_r) << (2 * L)) ^ (CW'(mid_s) << L) ^ CW'(p0_r);
    end

    // Main sequencer: handshakes, per-iteration accumulation, recombination and abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            phase     <= PH_NONE;
            c         <= '0;
            a_r       <= '0;
            b_r       <= '0;
            ph_r      <= PH_P0;
            cnt_r     <= '0;
            acc_r     <= '0;
            p0_r      <= '0;
            p1_r      <= '0;
            p2_r      <= '0;
        end else if (flush && (state_r != ST_IDLE)) begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            phase     <= PH_NONE;
            ph_r      <= PH_P0;
            cnt_r     <= '0;
            acc_r     <= '0;
            p0_r      <= '0;
            p1_r      <= '0;
            p2_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        ph_r     <= PH_P0;
                        cnt_r    <= '0;
                        acc_r    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    // phase reports the product worked on at this edge's iteration
                    phase <= ph_r;
                    if (cnt_r == CNT_LAST) begin
                        case (ph_r)
                            PH_P0:   p0_r <= acc_nx_s;
                            PH_P2:   p2_r <= acc_nx_s;
                            default: p1_r <= acc_nx_s;
                        endcase
                        acc_r <= '0;
                        cnt_r <= '0;
                        if (ph_r == PH_P1) begin
                            ph_r    <= PH_P0;
                            state_r <= ST_COMB;
                        end else begin
                            ph_r <= ph_r + 2'd1;
                        end
                    end else begin
                        acc_r <= acc_nx_s;
                        cnt_r <= cnt_r + CNTW'(1);
                    end
                end
                ST_COMB: begin
                    c         <= c_nx_s;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    phase     <= PH_NONE;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    phase    <= PH_NONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Self-checking bench for karatsuba_seq_ctrl: directed vector table, flush/reset sequences,
// and random jobs checked against a plain schoolbook carry-less product.
module tb_karatsuba_seq_ctrl;
    localparam int N   = 521;
    localparam int L   = N / 2;
    localparam int H   = N - L;
    localparam int W2  = 2 * N;
    localparam int LAT = 3 * H + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W2-1:0] c;
    logic          busy;
    logic [1:0]    phase;

    int n_checks;
    int n_errors;
    logic [W2-1:0] last_c;

    karatsuba_seq_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .busy(busy), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [W2-1:0] exp_c;
    } vec_t;
    vec_t vt[7];

    function automatic logic [W2-1:0] clmul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [W2-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (y[i]) r = r ^ (W2'(x) << i);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Iteration k (k = 1..3H after accept) works on product (k-1)/H: 0=P0, 1=P2, 2=P1
    function automatic logic [1:0] exp_phase(input int k);
        if (k >= 1 && k <= 3 * H) return 2'((k - 1) / H);
        return 2'd3;
    endfunction

    task automatic chk(input string nm, input logic [W2-1:0] act, input logic [W2-1:0] exp);
        int d;
        int lo;
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            d = 0;
            for (int i = W2 - 1; i >= 0; i--) if (act[i] !== exp[i]) d = i;
            lo = (d > W2 - 64) ? W2 - 64 : d;
            $display("FAIL %s: actual %h required %h (64-bit window from bit %0d)",
                     nm, act[lo +: 64], exp[lo +: 64], lo);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic run_job(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                           input logic [W2-1:0] exp_c, input bit rnd_ready, input bit with_flush);
        int k;
        int bad;
        bit taken;
        wait_idle();
        chk({name, "_idle_ready"}, W2'(in_ready), W2'(1));
        a = ta; b = tb_v; in_valid = 1'b1; flush = with_flush; out_ready = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        bad = 0;
        if (phase !== 2'd3 || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        k = 0;
        while (out_valid !== 1'b1 && k < 2000) begin
            if (k < 5) begin
                in_valid = 1'b1; a = ~ta; b = ~tb_v;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (phase !== exp_phase(k) || busy !== (k < LAT) || in_ready !== 1'b0 ||
                out_valid !== (k >= LAT)) bad++;
        end
        in_valid = 1'b0;
        chk({name, "_trace_mismatches"}, W2'(bad), W2'(0));
        chk({name, "_latency"}, W2'(k), W2'(LAT));
        chk({name, "_product"}, c, exp_c);
        bad = 0;
        k = 0;
        taken = 1'b0;
        while (!taken && k < 200) begin
            out_ready = rnd_ready ? ($urandom_range(0, 3) == 0) : 1'b1;
            @(posedge clk); #1;
            k++;
            if (out_ready) taken = 1'b1;
            else if (out_valid !== 1'b1 || in_ready !== 1'b0 || c !== exp_c) bad++;
        end
        out_ready = 1'b0;
        chk({name, "_hold_mismatches"}, W2'(bad), W2'(0));
        chk({name, "_release_valid_ready"}, W2'({out_valid, in_ready}), W2'(2'b01));
        chk({name, "_c_kept"}, c, exp_c);
        last_c = exp_c;
    endtask

    initial begin
        logic [N-1:0]  ra;
        logic [N-1:0]  rb;
        logic [W2-1:0] e;
        int            bad;
        n_checks = 0; n_errors = 0; last_c = '0;
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; a = '0; b = '0;

        vt[0].name = "one_x_one";  vt[0].a = '0; vt[0].a[0] = 1'b1; vt[0].b = vt[0].a;
        vt[0].exp_c = '0; vt[0].exp_c[0] = 1'b1;
        vt[1].name = "three_sq";   vt[1].a = '0; vt[1].a[1:0] = 2'b11; vt[1].b = vt[1].a;
        vt[1].exp_c = '0; vt[1].exp_c[2:0] = 3'b101;
        vt[2].name = "split_sq";   vt[2].a = '0; vt[2].a[260] = 1'b1; vt[2].a[0] = 1'b1;
        vt[2].b = vt[2].a; vt[2].exp_c = '0; vt[2].exp_c[520] = 1'b1; vt[2].exp_c[0] = 1'b1;
        vt[3].name = "top_sq";     vt[3].a = '0; vt[3].a[520] = 1'b1; vt[3].b = vt[3].a;
        vt[3].exp_c = '0; vt[3].exp_c[1040] = 1'b1;
        vt[4].name = "ones_x_one"; vt[4].a = '1; vt[4].b = '0; vt[4].b[0] = 1'b1;
        vt[4].exp_c = '0; vt[4].exp_c[N-1:0] = '1;
        vt[5].name = "zero_x_ones"; vt[5].a = '0; vt[5].b = '1; vt[5].exp_c = '0;
        vt[6].name = "five_x_seven"; vt[6].a = '0; vt[6].a[2:0] = 3'b101; vt[6].b = '0;
        vt[6].b[2:0] = 3'b111; vt[6].exp_c = '0; vt[6].exp_c[4:0] = 5'b11011;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", W2'({in_ready, out_valid, busy, phase}), W2'(5'b10011));
        chk("reset_c", c, '0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_job(vt[i].name, vt[i].a, vt[i].b, vt[i].exp_c, 1'b0, 1'b0);

        // Abort in MUL: flush raised after edge E0+300 takes effect at E0+301
        wait_idle();
        a = rand_vec(); b = rand_vec(); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_outputs", W2'({in_ready, out_valid, busy, phase}), W2'(5'b10011));
        chk("flush_c_unchanged", c, last_c);
        bad = 0;
        for (int k = 0; k < 900; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        chk("flush_no_output", W2'(bad), W2'(0));

        // Async reset in the middle of a job, then a fresh job
        a = rand_vec(); b = rand_vec(); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (400) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_outputs", W2'({in_ready, out_valid, busy, phase}), W2'(5'b10011));
        chk("midreset_c", c, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_job("after_reset_5x7", vt[6].a, vt[6].b, vt[6].exp_c, 1'b0, 1'b0);

        // flush together with in_valid in IDLE must not block the accept
        ra = rand_vec(); rb = rand_vec(); e = clmul(ra, rb);
        run_job("idle_flush_accept", ra, rb, e, 1'b1, 1'b1);

        for (int j = 0; j < 60; j++) begin
            ra = rand_vec(); rb = rand_vec();
            if (j % 10 == 3) ra[N-1:L] = '0;
            if (j % 10 == 7) rb[L-1:0] = '0;
            e = clmul(ra, rb);
            run_job($sformatf("rand%0d", j), ra, rb, e, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
